bsg_interval_meter: RTL

BSG_INTERVAL_METER -- requirements
Module: bsg_interval_meter

---
 rtl/bsg_interval_meter_pkg.sv | 10 +
 rtl/bsg_interval_meter_ctr.sv | 39 +++
 rtl/bsg_interval_meter.sv | 106 ++++++++++
 3 files changed

// File: rtl/bsg_interval_meter_pkg.sv
// rtl/bsg_interval_meter_pkg.sv - shared types for the interval meter
// Purpose: measurement state machine encoding.
package bsg_interval_meter_pkg;

  typedef enum logic {
    ARM     = 1'b0,
    MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/bsg_interval_meter_ctr.sv
// rtl/bsg_interval_meter_ctr.sv - saturating clear/up counter with count+1 output
// Purpose: holds the running interval count and presents count+1 with a
//          saturation flag for the measurement path.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset
//   clr_i            : clear counter to 0 (wins over up_i)
//   up_i             : increment, holding at all-ones
//   plus1_o          : count+1, clamped to all-ones
//   sat_o            : count+1 does not fit in width_p bits
module bsg_interval_meter_ctr #(
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clr_i,
  input  logic               up_i,
  output logic [width_p-1:0] plus1_o,
  output logic               sat_o
);

  logic [width_p-1:0] count_q;
  logic [width_p:0]   sum;

  // One extra bit catches the carry out of an all-ones count.
  assign sum     = {1'b0, count_q} + {{width_p{1'b0}}, 1'b1};
  assign sat_o   = sum[width_p];
  assign plus1_o = sum[width_p] ? {width_p{1'b1}} : sum[width_p-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (up_i && !sum[width_p]) begin
      count_q <= sum[width_p-1:0];
    end
  end

endmodule

// File: rtl/bsg_interval_meter.sv
// rtl/bsg_interval_meter.sv - measures enabled cycles between tick strobes
// Purpose: after an arming tick, reports each tick-to-tick interval through a
//          valid/ready output register; optional min/max tracking is enabled
//          by defining BSG_INTERVAL_METER_MINMAX_EN (else min_o/max_o are 0).
// Ports:
//   clk_i, reset_n_i   : clock, asynchronous active-low reset
//   en_i, tick_i       : count enable, event strobe (sampled only when enabled)
//   interval_o, sat_o  : measured interval and its saturation qualifier
//   v_o, ready_i       : output handshake
//   overrun_o          : sticky, a measurement was dropped
//   min_o, max_o       : smallest/largest accepted interval since reset
module bsg_interval_meter
  import bsg_interval_meter_pkg::*;
#(
  parameter int width_p = 128
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic               tick_i,
  output logic [width_p-1:0] interval_o,
  output logic               v_o,
  input  logic               ready_i,
  output logic               sat_o,
  output logic               overrun_o,
  output logic [width_p-1:0] min_o,
  output logic [width_p-1:0] max_o
);

  state_e             state_q, state_n;
  logic               sample;
  logic               meas;
  logic               accept;
  logic               drop;
  logic [width_p-1:0] plus1;
  logic               plus1_sat;

  assign sample = en_i & tick_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ARM;
    else            state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    meas    = 1'b0;
    if (sample) begin
      if (state_q == ARM) state_n = MEASURE;
      else                meas    = 1'b1;
    end
  end

  // Every sampled tick restarts the count, whether it arms or measures.
  bsg_interval_meter_ctr #(.width_p(width_p)) u_ctr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clr_i     (sample),
    .up_i      (en_i & ~tick_i & (state_q == MEASURE)),
    .plus1_o   (plus1),
    .sat_o     (plus1_sat)
  );

  // A held value being taken this cycle frees the register for the new one.
  assign accept = meas & (~v_o | ready_i);
  assign drop   = meas & v_o & ~ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      interval_o <= '0;
      sat_o      <= 1'b0;
      v_o        <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      if (accept) begin
        interval_o <= plus1;
        sat_o      <= plus1_sat;
        v_o        <= 1'b1;
      end else if (ready_i) begin
        v_o <= 1'b0;
      end
      if (drop) overrun_o <= 1'b1;
    end
  end

`ifdef BSG_INTERVAL_METER_MINMAX_EN
  logic [width_p-1:0] min_q, max_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      min_q <= '1;
      max_q <= '0;
    end else if (accept) begin
      if (plus1 < min_q) min_q <= plus1;
      if (plus1 > max_q) max_q <= plus1;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`else
  assign min_o = '0;
  assign max_o = '0;
`endif

endmodule
